// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   seg7_t      : segment vector a..g, bit 6 = a
//   SEG7_OFF_N  : all segments dark on active-low cathodes
//   SEG7_LUT    : active-high hex glyph table, index = nibble value
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_OFF_N = 7'h7F;

  localparam seg7_t SEG7_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
    7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
    7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
    7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : hex digit in
//   seg    : active-high segments a..g (bit 6 = a)
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG7_LUT[nibble];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode N-digit seven-segment
// display. A loaded value is double-buffered (pending -> shadow) so that a
// new value only appears at a frame boundary; one digit is lit per slot
// through a single shared decoder.
//   clk, reset  : system clock, asynchronous active-high reset
//   value_in    : packed nibbles, digit 0 rightmost
//   load        : one-cycle strobe capturing value_in
//   dp_in       : per-digit decimal point, live
//   digit_en    : per-digit enable mask, live
//   anodes_n    : active-low anode drive, at most one low
//   segments_n  : active-low cathodes a..g (bit 6 = a)
//   dp_n        : active-low decimal-point cathode
//   frame_done  : one-cycle pulse during the frame-wrap cycle
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic                    load,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [N_DIGITS-1:0]     anodes_n,
  output seg7_t                   segments_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pending;
  logic [4*N_DIGITS-1:0] shadow;
  logic                  pending_valid;

  logic                  tick;
  logic                  last_digit;
  logic                  wrap;
  logic                  fd_next;
  logic                  lit;
  logic [3:0]            nibble;
  seg7_t                 seg_dec;
  logic [N_DIGITS-1:0]   anode_sel_n;
  logic [N_DIGITS-1:0]   lzb;

  assign tick       = (cnt == CW'(REFRESH_DIV - 1));
  assign last_digit = (idx == IW'(N_DIGITS - 1));
  assign wrap       = tick && last_digit;
  // frame_done is a register, so it is set one cycle ahead to land
  // exactly on the wrap cycle (where a coincident load goes straight to shadow).
  assign fd_next    = last_digit && (cnt == CW'(REFRESH_DIV - 2));

  assign nibble = shadow[{idx, 2'b00} +: 4];

  seg7_decoder u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blanked while
  // it and everything above it are zero. Digit 0 is never blanked.
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    lzb        = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      zero_above = zero_above && (shadow[4*(N_DIGITS-1-k) +: 4] == 4'h0);
      lzb[N_DIGITS-1-k] = zero_above && (k != N_DIGITS - 1);
    end
  end
`else
  always_comb begin
    lzb = '0;
  end
`endif

  always_comb begin
    lit = (cnt >= CW'(BLANK_CYCLES)) && digit_en[idx] && !lzb[idx];
    anode_sel_n      = '1;
    anode_sel_n[idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
      anodes_n      <= '1;
      segments_n    <= SEG7_OFF_N;
      dp_n          <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= last_digit ? '0 : idx + IW'(1);
      end

      if (load) begin
        pending <= value_in;
      end

      if (wrap) begin
        if (load) begin
          shadow <= value_in;
        end else if (pending_valid) begin
          shadow <= pending;
        end
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end

      anodes_n   <= lit ? anode_sel_n : '1;
      segments_n <= lit ? ~seg_dec : SEG7_OFF_N;
      dp_n       <= !(lit && dp_in[idx]);
      frame_done <= fd_next;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with N_DIGITS=4,
// REFRESH_DIV=4, BLANK_CYCLES=1 (16-cycle frames). Expected pin values for
// each frame are queued when the frame's stimulus is set up and popped as
// the frame is observed on the falling clock edge.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  anodes_n;
  logic [6:0]  segments_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  // {frame_done, anodes_n, segments_n, dp_n}
  logic [12:0] sbq [$];
  logic [6:0]  lut [16];

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .anodes_n   (anodes_n),
    .segments_n (segments_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected {anodes_n, segments_n, dp_n} for frame cycle c showing value v.
  function automatic logic [11:0] pins(input logic [15:0] v, input int c);
    int          slot;
    int          pos;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        on;
    logic [15:0] upper;
    slot  = c / RD;
    pos   = c % RD;
    upper = v >> (4 * slot);
    nib   = upper[3:0];
    on    = (pos >= BC) && digit_en[slot];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0 && upper == 16'h0) on = 1'b0;
`endif
    if (on) begin
      an       = 4'hF;
      an[slot] = 1'b0;
      return {an, ~lut[nib], ~dp_in[slot]};
    end
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sync_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check("sync_frame_done", {12'h0, found}, 13'h1);
  endtask

  // Called on the falling edge where frame_done is high; returns on the
  // falling edge of the next frame_done. Sample j=1 still shows the last
  // digit-3 cycle of the previous frame.
  task automatic check_frame(input logic [15:0] prevv, input logic [15:0] curv,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
    logic [12:0] exp;
    sbq.push_back({1'b0, pins(prevv, N*RD-1)});
    for (int c = 0; c < N*RD-1; c++)
      sbq.push_back({(c == N*RD-2), pins(curv, c)});
    for (int j = 1; j <= N*RD; j++) begin
      @(negedge clk);
      load = 1'b0;
      exp  = sbq.pop_front();
      check($sformatf("frame_%h_j%0d", curv, j),
            {frame_done, anodes_n, segments_n, dp_n}, exp);
      if (j == la) begin load = 1'b1; value_in = va; end
      if (j == lb) begin load = 1'b1; value_in = vb; end
    end
  endtask

  initial begin
    lut = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0;
    digit_en = 4'hF;
    dp_in    = 4'h0;

    repeat (3) @(negedge clk);
    check("reset_hold", {frame_done, anodes_n, segments_n, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
    reset = 1'b0;

    // Asynchronous reset in the middle of a lit slot.
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("reset_async", {frame_done, anodes_n, segments_n, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (anodes_n != 4'hF) break;
    end
    check("first_lit_digit0", {9'h0, anodes_n}, {9'h0, 4'b1110});

    sync_frame();
    // Shadow still zero; load 1234 mid-frame.
    check_frame(16'h0000, 16'h0000, 5, 16'h1234, -1, 16'h0);
    // 1234 shown; two loads mid-frame, last one wins next frame.
    check_frame(16'h0000, 16'h1234, 3, 16'h1111, 10, 16'h2222);
    check_frame(16'h1234, 16'h2222, -1, 16'h0, -1, 16'h0);
    // Load coinciding with frame_done.
    load = 1'b1; value_in = 16'hABCD;
    check_frame(16'h2222, 16'hABCD, -1, 16'h0, -1, 16'h0);
    // Partial enable mask with decimal point on digit 0.
    digit_en = 4'b0101; dp_in = 4'b0001;
    check_frame(16'hABCD, 16'hABCD, -1, 16'h0, -1, 16'h0);
    // Leading zeros.
    digit_en = 4'hF; dp_in = 4'h0;
    load = 1'b1; value_in = 16'h0007;
    check_frame(16'hABCD, 16'h0007, -1, 16'h0, -1, 16'h0);
    check_frame(16'h0007, 16'h0007, -1, 16'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a common-anode N-digit seven-segment display. It latches a packed hexadecimal value through a load handshake and double-buffers it so that updates land only at frame boundaries. It cycles one digit at a time through a single shared hex-to-segment decoder and drives active-low anode and segment pins. It sits between the user datapath (counters, ALU results) and the board display pins.

## Interface
- N_DIGITS, 8: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off (anti-ghosting); < REFRESH_DIV.
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- value_in  in  4*N_DIGITS  packed nibbles; digit i = value_in[4i+3:4i], digit 0 rightmost.
- load  in  1  single-cycle strobe; captures value_in.
- dp_in  in  N_DIGITS  decimal point per digit, active-high; sampled live.
- digit_en  in  N_DIGITS  per-digit enable mask; sampled live.
- anodes_n  out  N_DIGITS  anode drive, active-low, at most one bit low.
- segments_n  out  7  cathodes a..g, bit 6 = a, active-low.
- dp_n  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse at frame wrap.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. The slot tick occurs when cnt == REFRESH_DIV-1.
- Digit index idx advances on each tick and wraps N_DIGITS-1 → 0. A wrap is a frame boundary.
- Registers: pending (4*N_DIGITS), pending_valid, shadow (4*N_DIGITS). Only shadow is displayed.
- load=1: pending ← value_in and pending_valid ← 1. If several loads occur in one frame, the last one wins.
- At a frame boundary: if load=1 in the same cycle, shadow ← value_in; otherwise, if pending_valid=1, shadow ← pending. In both cases pending_valid ← 0. frame_done is asserted for that cycle.
- Digit lit condition: cnt ≥ BLANK_CYCLES and digit_en[idx]=1 (and not blanked by the configuration feature below).
- When a digit is lit:
  - anodes_n has only bit idx low.
  - segments_n = ~decode(shadow nibble idx).
  - dp_n = ~dp_in[idx].
- When no digit is lit: anodes_n = all ones, segments_n = 7'h7F, dp_n = 1.
- Decoder encoding (abcdefg, active-high before inversion):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111

## Timing
- All outputs are registered. Pins reflect the cnt/idx state of the previous cycle, so latency is 1 cycle from a state change to the pins.
- Reset values:
  - cnt=0, idx=0, shadow=0, pending=0, pending_valid=0.
  - anodes_n = all ones, segments_n = 7'h7F, dp_n = 1, frame_done = 0.
- Reset asserted mid-frame forces the reset values immediately (asynchronous). Scanning restarts at digit 0, cnt 0.
- A value loaded at an arbitrary time is visible on digit 0 no later than N_DIGITS*REFRESH_DIV + BLANK_CYCLES + 1 cycles afterwards.
- A frame lasts N_DIGITS*REFRESH_DIV cycles, and frame_done pulses exactly once per frame.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i is blanked (anode off) when shadow nibbles i..N_DIGITS-1 are all zero and i ≠ 0.
  - Digit 0 is always eligible.
  - The decimal point of a blanked digit is also off.
- LEADING_ZERO_BLANK_EN undefined: every enabled digit is shown, including leading zeros.

## Structure
- Shared package display_pkg holds:
  - typedef seg7_t (logic [6:0]);
  - constant SEG7_OFF_N = 7'h7F;
  - the 16-entry decode constants.
- Sub-module seg7_decoder: combinational, nibble in, active-high seg7_t out. It is instantiated once and driven by the muxed shadow nibble.

## Test plan
Bench parameters unless noted: N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: assert reset mid-slot → anodes_n=4'hF, segments_n=7'h7F, dp_n=1 in the same cycle; after release, the first lit digit is digit 0.
- Load 16'h1234 then wait for frame_done → next frame shows:
  - digit0: anodes_n=4'b1110, segments_n=7'h4C;
  - digit1: segments_n=7'h06;
  - digit2: segments_n=7'h12;
  - digit3: segments_n=7'h4F.
- Load 16'h1111 mid-frame, then load 16'h2222 before the boundary → the current frame is unchanged and every digit of the next frame shows 7'h12.
- Load coinciding with frame_done → the new value is shown starting with the digit 0 slot of the new frame.
- digit_en=4'b0101, dp_in=4'b0001 → anodes_n bits 1 and 3 never go low; dp_n=0 only while digit 0 is lit; each slot is dark for exactly 1 cycle.
- Value 16'h0007:
  - with LEADING_ZERO_BLANK_EN: only digit 0 is lit, segments_n=7'h0F;
  - without it: digits 1–3 light with segments_n=7'h01.
